mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   Initiator side of the word RAM interface: takes one load/store request from the core
//   and performs byte, halfword and word accesses on the word-addressed RAM.
//   Handles sign/zero extension, read-modify-write for sub-word stores and error checks.
//   Sits between the execute/memory stage and ram. Only one request is in flight at a time.
// PARAMETERS
//   SIZE_WORDS  32  words in the attached RAM; the valid byte range is 0..SIZE_WORDS*4-1
// PORTS
//   clock             in   1   system clock; all state changes on posedge
//   reset             in   1   asynchronous, active-high
//   req_valid         in   1   request present
//   req_ready         out  1   unit can accept a request (high only in IDLE)
//   req_write         in   1   1=store, 0=load
//   req_funct3        in   3   RV32I funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//   req_address       in   32  byte address
//   req_data          in   32  store data; low byte/halfword used for SB/SH
//   resp_valid        out  1   one-cycle pulse: request complete
//   resp_data         out  32  load result, extended; 0 for stores and errors
//   resp_error        out  1   qualifies resp_valid: misaligned, out of range or bad funct3
//   mem_address       out  32  to ram.address, always word-aligned ({addr[31:2],2'b00})
//   mem_input_data    out  32  to ram.input_data
//   mem_should_write  out  1   to ram.should_write; ram writes on negedge clock
//   mem_output_data   in   32  from ram.output_data (combinational read)
// BEHAVIOUR
//   Reset: state=IDLE; resp_valid, resp_error, mem_should_write=0; resp_data,
//     mem_address, mem_input_data=0. All latched request fields are cleared.
//   States: IDLE, READ, WRITE, RESP.
//   IDLE: req_ready=1. A request is accepted on the posedge where req_valid=1.
//     On acceptance: latch address, funct3, write and data. Error if any of these holds:
//     halfword with addr[0]!=0; word with addr[1:0]!=0; addr>=SIZE_WORDS*4;
//     load funct3 in {3,6,7}; store funct3>2.
//     Next state: RESP if error; WRITE if SW; otherwise READ.
//   READ (1 cycle): mem_address is valid. Capture mem_output_data at posedge.
//     Load: byte lane = addr[1:0] (little-endian); LB/LH sign-extend, LBU/LHU
//       zero-extend. Result goes to resp_data. Next state RESP.
//     SB/SH: merge the low byte/halfword of req_data into the captured word at that
//       lane; the other lanes are unchanged. The merged word goes to mem_input_data.
//       Next state WRITE.
//   WRITE (1 cycle): mem_should_write=1 only in this state (decoded from the state flop,
//     so it is glitch-free). mem_input_data is stable for the whole cycle. Next state RESP.
//   RESP (1 cycle): resp_valid=1 with resp_data and resp_error. Next state IDLE.
//     resp_data is held until the next response. A new request is accepted only after
//     the unit returns to IDLE.
//   Latency, from the accept edge to the cycle in which resp_valid is high:
//     load 2 cycles; SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
//   Errors never assert mem_should_write, so RAM contents are untouched.
//   Reset during WRITE: mem_should_write drops immediately. If reset rises before the
//     negedge of that cycle, no write occurs. The unit returns to IDLE with no response.
//   req_* inputs are ignored outside IDLE.
// TESTING
//   RAM word 1 = 0x8899AABB; LB addr 5 -> resp_data=0xFFFFFFAA, resp_valid 2 cycles after accept
//   Same RAM word; LBU addr 7 -> 0x00000088; LHU addr 6 -> 0x00008899; LH addr 4 -> 0xFFFFAABB
//   SB addr 6, data 0x11 on word 0x8899AABB -> ram word 1 = 0x8811AABB,
//     should_write high exactly 1 cycle
//   SW addr 8, data 0xDEADBEEF -> no READ state, word 2 = 0xDEADBEEF, resp 2 cycles after accept
//   LW addr 2; SH addr 3; LW addr 128 (SIZE_WORDS=32); funct3=3 load -> resp_error=1,
//     resp_data=0, RAM unchanged
//   Reset asserted before negedge in WRITE of SH addr 0 -> RAM unchanged, state IDLE,
//     req_ready=1, no resp_valid

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Initiator side of the word RAM interface. Accepts one load/store request
//   at a time from the core. It performs byte, halfword and word accesses on a
//   word-addressed RAM. Loads are sign- or zero-extended. Sub-word stores use
//   read-modify-write. Misaligned, out-of-range and bad-funct3 requests finish
//   with an error response and never touch the RAM.
//
// Ports
//   clock, reset        system clock; asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_funct3          RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_address         byte address
//   req_data            store data (low byte/halfword for SB/SH)
//   resp_valid          one-cycle completion pulse
//   resp_data           extended load result; 0 for stores and errors
//   resp_error          error flag, qualified by resp_valid
//   mem_address         word-aligned RAM address
//   mem_input_data      RAM write data
//   mem_should_write    RAM write enable (RAM writes on negedge)
//   mem_output_data     RAM combinational read data
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int SIZE_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_should_write,
  input  logic [31:0] mem_output_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [31:0] LP_BYTE_LIMIT = 32'(SIZE_WORDS * 4);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_write;
  logic [15:0] r_data;
  logic        r_error;
  logic [31:0] r_resp_data;
  logic [31:0] r_mem_input_data;
  logic        w_req_error;
  logic        w_req_is_sw;

  // Extract the addressed byte/halfword from a RAM word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'd0, b};
      3'd5:    res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Insert the low byte/halfword of the store data into a RAM word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  lane,
                                              input logic        half);
    logic [31:0] res;
    res = word;
    if (half) begin
      if (lane[1]) begin
        res[31:16] = data;
      end else begin
        res[15:0] = data;
      end
    end else begin
      case (lane)
        2'd0:    res[7:0]   = data[7:0];
        2'd1:    res[15:8]  = data[7:0];
        2'd2:    res[23:16] = data[7:0];
        2'd3:    res[31:24] = data[7:0];
        default: res = word;
      endcase
    end
    return res;
  endfunction

  // Error classification of the incoming request.
  always_comb begin
    w_req_error = 1'b0;
    w_req_is_sw = req_write && (req_funct3 == 3'd2);
    if (req_write && (req_funct3 > 3'd2)) begin
      w_req_error = 1'b1;
    end else if (!req_write && ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11))) begin
      w_req_error = 1'b1;
    end else if ((req_funct3[1:0] == 2'd1) && req_address[0]) begin
      w_req_error = 1'b1;
    end else if ((req_funct3[1:0] == 2'd2) && (req_address[1:0] != 2'd0)) begin
      w_req_error = 1'b1;
    end else if (req_address >= LP_BYTE_LIMIT) begin
      w_req_error = 1'b1;
    end else begin
      w_req_error = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_error) begin
            w_next_state = ST_RESP;
          end else if (w_req_is_sw) begin
            w_next_state = ST_WRITE;
          end else begin
            w_next_state = ST_READ;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (r_write) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      ST_WRITE: w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request latch and datapath registers; every value entering RESP is
  // written on the edge that enters RESP so resp_data holds until then.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr           <= 32'd0;
      r_funct3         <= 3'd0;
      r_write          <= 1'b0;
      r_data           <= 16'd0;
      r_error          <= 1'b0;
      r_resp_data      <= 32'd0;
      r_mem_input_data <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_address;
            r_funct3 <= req_funct3;
            r_write  <= req_write;
            r_data   <= req_data[15:0];
            r_error  <= w_req_error;
            if (w_req_error) begin
              r_resp_data <= 32'd0;
            end else if (w_req_is_sw) begin
              r_mem_input_data <= req_data;
            end
          end
        end
        ST_READ: begin
          if (r_write) begin
            r_mem_input_data <= store_merge(mem_output_data, r_data, r_addr[1:0], r_funct3[0]);
          end else begin
            r_resp_data <= load_extend(mem_output_data, r_addr[1:0], r_funct3);
          end
        end
        ST_WRITE: r_resp_data <= 32'd0;
        ST_RESP:  r_resp_data <= r_resp_data;
        default:  r_resp_data <= r_resp_data;
      endcase
    end
  end

  // Outputs are decoded straight from flops, so the write strobe is glitch-free
  // and drops as soon as reset is asserted.
  assign req_ready        = (r_state == ST_IDLE);
  assign resp_valid       = (r_state == ST_RESP);
  assign resp_error       = (r_state == ST_RESP) && r_error;
  assign resp_data        = r_resp_data;
  assign mem_address      = {r_addr[31:2], 2'b00};
  assign mem_input_data   = r_mem_input_data;
  assign mem_should_write = (r_state == ST_WRITE);

endmodule
